ks_note_seq: RTL and testbench

Step sequencer and excitation source that sits directly upstream of the Karplus-Strong string voice. It plays a loadable table of delay-line periods at a programmable tempo. For each note step it drives one pluck pulse with a stable, range-clamped period to the string. It also supplies the free-running PRBS noise bits that the string uses for its noise burst and drum sign flip.

---
 rtl/ks_note_seq.sv | 137 +++++++++++++
 tb/tb_ks_note_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_seq.sv
// Step sequencer feeding the Karplus-Strong string: plays a table of periods at a set tempo,
// issuing one fixed-width pluck per note, and exports free-running PRBS noise bits.
module ks_note_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_LENGTH  = 64,
    parameter int STEPS       = 8,
    parameter int TEMPO_WIDTH = 16,
    parameter int PLUCK_HOLD  = 4,
    parameter int PRBS_WIDTH  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     run_i,
    input  logic [TEMPO_WIDTH-1:0]   tempo_i,
    input  logic [$clog2(STEPS)-1:0] len_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(STEPS)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_period_i,
    output logic                     pluck_o,
    output logic [DATA_WIDTH-1:0]    period_o,
    output logic [PRBS_WIDTH-1:0]    prbs_data_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic                     step_stb_o,
    output logic                     active_o
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int HOLD_W = $clog2(PLUCK_HOLD + 1);
    localparam logic [DATA_WIDTH-1:0]  PERIOD_MAX = DATA_WIDTH'(MAX_LENGTH - 1);
    localparam logic [TEMPO_WIDTH-1:0] TEMPO_MIN  = TEMPO_WIDTH'(PLUCK_HOLD + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   seq_table [STEPS];
    logic [15:0]             lfsr;
    logic                    lfsr_fb;
    logic [TEMPO_WIDTH-1:0]  tick_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic                    launch;
    logic [STEP_W-1:0]       launch_step;
    logic [DATA_WIDTH-1:0]   launch_entry;
    logic [DATA_WIDTH-1:0]   launch_period;
    logic [TEMPO_WIDTH-1:0]  teff;

    assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign prbs_data_o = lfsr[PRBS_WIDTH-1:0];

    // Table read happens before this edge's write lands, so a colliding launch sees old data.
    assign launch_entry  = seq_table[launch_step];
    assign launch_period = (launch_entry > PERIOD_MAX) ? PERIOD_MAX : launch_entry;
    assign teff          = (tempo_i < TEMPO_MIN) ? TEMPO_MIN : tempo_i;

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_step = '0;
        case (state)
            S_IDLE: begin
                if (run_i) begin
                    launch    = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!run_i) begin
                    state_nxt = S_IDLE;
                end else if (hold_cnt == '0) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!run_i) begin
                    state_nxt = S_IDLE;
                end else if (tick_cnt == '0) begin
                    launch      = 1'b1;
                    state_nxt   = S_HOLD;
                    launch_step = (step_o >= len_i) ? '0 : step_o + STEP_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pluck_o    <= 1'b0;
            period_o   <= PERIOD_MAX;
            step_o     <= '0;
            step_stb_o <= 1'b0;
            active_o   <= 1'b0;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            lfsr       <= 16'hACE1;
            for (int i = 0; i < STEPS; i++) begin
                seq_table[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            active_o   <= (state_nxt != S_IDLE);
            step_stb_o <= launch;
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            if (wr_en_i) begin
                seq_table[wr_addr_i] <= wr_period_i;
            end
            if (launch) begin
                step_o   <= launch_step;
                tick_cnt <= teff - TEMPO_WIDTH'(1);
                hold_cnt <= HOLD_W'(PLUCK_HOLD - 1);
                // A rest keeps the previous period so the string never sees a spurious change.
                if (launch_entry != '0) begin
                    pluck_o  <= 1'b1;
                    period_o <= launch_period;
                end else begin
                    pluck_o  <= 1'b0;
                end
            end else begin
                if (tick_cnt != '0) begin
                    tick_cnt <= tick_cnt - TEMPO_WIDTH'(1);
                end
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                if (state_nxt != S_HOLD) begin
                    pluck_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ks_note_seq.sv
// Scoreboard bench for ks_note_seq: directed phases queue expected launches and pluck widths,
// independent monitors pop and compare them, and a reference LFSR tracks the noise output.
module tb_ks_note_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_i = 1'b0;
    logic [15:0] tempo_i = 16'd100;
    logic [2:0]  len_i = 3'd3;
    logic        wr_en_i = 1'b0;
    logic [2:0]  wr_addr_i = 3'd0;
    logic [7:0]  wr_period_i = 8'd0;
    logic        pluck_o;
    logic [7:0]  period_o;
    logic [1:0]  prbs_data_o;
    logic [2:0]  step_o;
    logic        step_stb_o;
    logic        active_o;

    ks_note_seq dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .run_i       (run_i),
        .tempo_i     (tempo_i),
        .len_i       (len_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_period_i (wr_period_i),
        .pluck_o     (pluck_o),
        .period_o    (period_o),
        .prbs_data_o (prbs_data_o),
        .step_o      (step_o),
        .step_stb_o  (step_stb_o),
        .active_o    (active_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at;
        int step;
        int pluck;
        int period;
    } launch_t;

    launch_t     exp_q[$];
    int          width_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          run_len = 0;
    bit          mon_on = 1'b0;
    bit          lfsr_on = 1'b0;
    logic [15:0] model_lfsr = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic run, input int tempo, input int len);
        run_i   = run;
        tempo_i = 16'(tempo);
        len_i   = 3'(len);
    endtask

    task automatic writeEntry(input int addr, input int value);
        wr_en_i     = 1'b1;
        wr_addr_i   = 3'(addr);
        wr_period_i = 8'(value);
        @(negedge clk);
        wr_en_i     = 1'b0;
    endtask

    task automatic expectLaunch(input int at, input int step, input int pluck, input int period);
        launch_t e;
        e.at     = at;
        e.step   = step;
        e.pluck  = pluck;
        e.period = period;
        exp_q.push_back(e);
    endtask

    // Reference noise generator built from the polynomial, reset alongside the DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_lfsr <= 16'hACE1;
            lfsr_on    <= 1'b1;
        end else if (lfsr_on) begin
            model_lfsr <= {model_lfsr[0] ^ model_lfsr[2] ^ model_lfsr[3] ^ model_lfsr[5],
                           model_lfsr[15:1]};
        end
    end

    always @(negedge clk) begin
        if (lfsr_on) checkOutput("prbs", int'(prbs_data_o), int'(model_lfsr[1:0]));
    end

    always @(negedge clk) begin : launch_monitor
        launch_t e;
        if (mon_on) begin
            if (step_stb_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stray_stb", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("launch_at", cyc, e.at);
                    checkOutput("launch_step", int'(step_o), e.step);
                    checkOutput("launch_pluck", int'(pluck_o), e.pluck);
                    checkOutput("launch_period", int'(period_o), e.period);
                end
            end
            if (pluck_o === 1'b1) begin
                run_len++;
            end else if (run_len != 0) begin
                if (width_q.size() == 0) checkOutput("stray_pluck", run_len, 0);
                else checkOutput("pluck_width", run_len, width_q.pop_front());
                run_len = 0;
            end
        end
    end

    initial begin
        int base;

        applyStimulus(1'b0, 100, 3);
        repeat (3) @(negedge clk);
        checkOutput("rst_pluck", int'(pluck_o), 0);
        checkOutput("rst_period", int'(period_o), 63);
        checkOutput("rst_step", int'(step_o), 0);
        checkOutput("rst_stb", int'(step_stb_o), 0);
        checkOutput("rst_active", int'(active_o), 0);
        checkOutput("rst_lfsr", int'(dut.lfsr), 'hACE1);
        checkOutput("rst_prbs", int'(prbs_data_o), 1);
        mon_on = 1'b1;

        // Free-running noise with the sequencer held off.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("lfsr_1", int'(dut.lfsr), 'h5670);
        checkOutput("prbs_1", int'(prbs_data_o), 0);
        @(negedge clk);
        checkOutput("lfsr_2", int'(dut.lfsr), 'hAB38);
        checkOutput("prbs_2", int'(prbs_data_o), 0);
        repeat (5) @(negedge clk);

        // Basic loop with a rest at step 2, then stop during the step-1 hold.
        writeEntry(0, 20);
        writeEntry(1, 40);
        writeEntry(2, 0);
        writeEntry(3, 63);
        base = cyc;
        expectLaunch(base + 1,   0, 1, 20);
        expectLaunch(base + 101, 1, 1, 40);
        expectLaunch(base + 201, 2, 0, 40);
        expectLaunch(base + 301, 3, 1, 63);
        expectLaunch(base + 401, 0, 1, 20);
        expectLaunch(base + 501, 1, 1, 40);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(2);
        applyStimulus(1'b1, 100, 3);
        repeat (502) @(negedge clk);
        applyStimulus(1'b0, 100, 3);
        @(negedge clk);
        checkOutput("stop_pluck", int'(pluck_o), 0);
        checkOutput("stop_active", int'(active_o), 0);
        checkOutput("stop_step", int'(step_o), 1);
        checkOutput("stop_period", int'(period_o), 40);

        // Restart must begin again at step 0.
        base = cyc;
        expectLaunch(base + 1, 0, 1, 20);
        width_q.push_back(1);
        applyStimulus(1'b1, 100, 3);
        @(negedge clk);
        checkOutput("restart_active", int'(active_o), 1);
        applyStimulus(1'b0, 100, 3);
        repeat (3) @(negedge clk);

        // Period clamp and tempo floor.
        writeEntry(0, 200);
        writeEntry(1, 1);
        base = cyc;
        expectLaunch(base + 1,  0, 1, 63);
        expectLaunch(base + 7,  1, 1, 1);
        expectLaunch(base + 13, 0, 1, 63);
        expectLaunch(base + 19, 1, 1, 1);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(2);
        applyStimulus(1'b1, 2, 1);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 2, 1);
        repeat (3) @(negedge clk);

        // Table write landing on the same edge that launches that step.
        writeEntry(0, 10);
        writeEntry(1, 30);
        base = cyc;
        expectLaunch(base + 1,  0, 1, 10);
        expectLaunch(base + 9,  1, 1, 30);
        expectLaunch(base + 17, 0, 1, 10);
        expectLaunch(base + 25, 1, 1, 50);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(4);
        width_q.push_back(2);
        applyStimulus(1'b1, 8, 1);
        repeat (8) @(negedge clk);
        wr_en_i     = 1'b1;
        wr_addr_i   = 3'd1;
        wr_period_i = 8'd50;
        @(negedge clk);
        wr_en_i     = 1'b0;
        repeat (17) @(negedge clk);
        applyStimulus(1'b0, 8, 1);
        repeat (3) @(negedge clk);

        // Reset during WAIT, then run the whole table to show it was cleared.
        base = cyc;
        expectLaunch(base + 1, 0, 1, 10);
        width_q.push_back(4);
        applyStimulus(1'b1, 8, 1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_period", int'(period_o), 63);
        checkOutput("midrst_pluck", int'(pluck_o), 0);
        checkOutput("midrst_step", int'(step_o), 0);
        checkOutput("midrst_active", int'(active_o), 0);
        checkOutput("midrst_stb", int'(step_stb_o), 0);
        checkOutput("midrst_lfsr", int'(dut.lfsr), 'hACE1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 6, 7);
        base = cyc;
        for (int k = 0; k < 8; k++) begin
            expectLaunch(base + 1 + 6 * k, k, 0, 63);
        end
        repeat (44) @(negedge clk);
        applyStimulus(1'b0, 6, 7);
        repeat (5) @(negedge clk);

        checkOutput("launches_left", exp_q.size(), 0);
        checkOutput("widths_left", width_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
